aes_inv_key_schedule: RTL and testbench
=======================================

# aes_inv_key_schedule

Reverse AES-128 round-key generator for the decryption datapath. It is the counterpart of the forward key expansion: it starts from the round-10 key and produces round keys 10, 9, … 0 on the fly, one per handshake, without storing the full 176-byte expansion. The inverse-cipher round controller consumes its output in the order decryption needs it.

## Interface
Parameters:
- NR, 10, number of rounds; fixed for AES-128. Other values are unsupported.

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous active-high reset.
- Start  in  1  one-cycle pulse that loads InKey. Accepted only while Ry=1.
- InKey  in  128  round-10 key. When AES_INV_KEY_DERIVE_EN is defined, this is the original cipher key instead. Byte 0 is InKey[127:120]; word 0 is InKey[127:96].
- Next  in  1  consumer has taken Key; advance to the next lower round. Honoured only while Valid=1.
- Key  out  128  current round key, same byte order as InKey.
- Round  out  4  round index of Key, 10 down to 0.
- Valid  out  1  Key and Round are meaningful.
- Ry  out  1  idle and able to accept Start.

## Operation
- States: IDLE, DERIVE (present only with the macro), EMIT.
- IDLE: Ry=1, Valid=0.
  - On Start: load InKey into the key register and latch the round counter.
  - Without the macro: go to EMIT with Round=10.
  - With the macro: go to DERIVE with Round=0.
- DERIVE: each cycle applies one forward step, then Round+1. When Round reaches 10, go to EMIT. Ry=0, Valid=0.
  - Forward step: w4 = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r]
  - w5 = w1 ^ w4; w6 = w2 ^ w5; w7 = w3 ^ w6
- EMIT: Valid=1, Ry=0.
  - On Next with Round>0: apply one inverse step and decrement Round.
  - On Next with Round=0: go to IDLE.
- Inverse step, where current words are w0..w3 and the step is leaving round r:
  - p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon[r]
- RotWord(b0,b1,b2,b3) = (b1,b2,b3,b0).
- SubWord applies the forward S-box to each byte; the inverse S-box is not used.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36, placed in the top byte of the word.
- All XORs are 32-bit, with no carries.
- Start while Ry=0 is ignored.
- Next while Valid=0 is ignored.
- Start and Next in the same cycle: Next governs. Start is dropped unless the state is IDLE.

## Timing
- Reset values: Key=0, Round=0, Valid=0, Ry=1; state is IDLE.
- Rst mid-operation aborts immediately to the reset values. No partial key survives.
- Start accepted in cycle t:
  - Without the macro: Valid=1, Round=10, Key=InKey at t+1.
  - With the macro: Valid=1 at t+11, after 10 DERIVE cycles.
- Next sampled high in cycle t while in EMIT: the new Key/Round are visible at t+1 and Valid stays high, giving one key per cycle if Next is held.
- Next at Round=0: Valid=0 and Ry=1 at t+1. A new Start is accepted from that cycle.
- Key and Round are registered outputs, stable whenever Valid=1 and Next=0.
- Full path of 3 XORs + S-box + Rcon XOR is single-cycle. There is no pipelining.

## Configuration
- AES_INV_KEY_DERIVE_EN:
  - Defined: InKey is the original cipher key. The block derives round 10 internally in DERIVE (10 cycles) and then emits 10..0. Round 0 output must equal InKey.
  - Undefined: the DERIVE state and its forward-step logic are absent. InKey is taken as the round-10 key and start latency is 1 cycle.

## Test plan
- Macro undefined: Start with InKey=d014f9a8c9ee2589e13f0cc8b6630ca6 → at t+1, Round=10 and Key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same load, one Next → Round=9, Key=ac7766f319fadc2128d12941575c006e.
- Same load, Next held high 10 cycles → Round=0, Key=2b7e151628aed2a6abf7158809cf4f3c. Eleventh Next → Valid=0, Ry=1. Round 1 key seen in between is a0fafe1788542cb123a339392a6c7605.
- Macro defined: Start with InKey=2b7e151628aed2a6abf7158809cf4f3c → Valid=1 exactly 11 cycles later with round-10 key d014f9a8…0ca6. The final emitted key equals InKey.
- Protocol checks:
  - Start pulsed during EMIT → ignored; sequence unchanged.
  - Next with Valid=0 → no change.
  - Start and Next together in EMIT → advance only.
- Rst asserted asynchronously mid-sequence at Round=5 → outputs immediately 0/0/0/Ry=1. A following Start restarts cleanly from Round=10.

Source files
------------

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule
// Reverse AES-128 round-key generator for the inverse cipher. Loads the
// round-10 key and walks it back to round 0, one key per Next handshake,
// using the inverse key-expansion step so that no expanded key table is kept.
//
// Optional feature macro: AES_INV_KEY_DERIVE_EN
//   defined   - InKey is the original cipher key; the block runs ten forward
//               expansion steps (DERIVE) to reach round 10 before emitting.
//   undefined - InKey is already the round-10 key; DERIVE does not exist.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for Start; Ry=1, Valid=0
// DERIVE | forward-expanding cipher key up to round 10 (macro only)
// EMIT   | Key/Round valid; Next steps down one round, or exits at 0

module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] InKey,
    input  logic         Next,
    output logic [127:0] Key,
    output logic [3:0]   Round,
    output logic         Valid,
    output logic         Ry
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef AES_INV_KEY_DERIVE_EN
    typedef enum logic [1:0] {IDLE, DERIVE, EMIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;

    // SubWord(RotWord(w)): rotate one byte left, then S-box each byte.
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
    endfunction

    // Round constant for round r, in the top byte of the word.
    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return {c, 24'h000000};
    endfunction

    // Recover round r-1 key from round r key; r selects the Rcon that was
    // used to produce round r.
    function automatic logic [127:0] inv_step(input logic [127:0] k,
                                              input logic [3:0]   r);
        logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        p0 = w0 ^ sub_rot(p3) ^ rcon(r);
        return {p0, p1, p2, p3};
    endfunction

`ifdef AES_INV_KEY_DERIVE_EN
    // Produce round r key from round r-1 key.
    function automatic logic [127:0] fwd_step(input logic [127:0] k,
                                              input logic [3:0]   r);
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        w4 = w0 ^ sub_rot(w3) ^ rcon(r);
        w5 = w1 ^ w4;
        w6 = w2 ^ w5;
        w7 = w3 ^ w6;
        return {w4, w5, w6, w7};
    endfunction
`endif

    // State, key and round registers; reset clears any partial key.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    // Next-state, key and round update.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    key_d = InKey;
`ifdef AES_INV_KEY_DERIVE_EN
                    state_d = DERIVE;
                    round_d = 4'd0;
`else
                    state_d = EMIT;
                    round_d = LAST_ROUND;
`endif
                end
            end
`ifdef AES_INV_KEY_DERIVE_EN
            DERIVE: begin
                key_d   = fwd_step(key_q, round_q + 4'd1);
                round_d = round_q + 4'd1;
                if (round_q == LAST_ROUND - 4'd1) begin
                    state_d = EMIT;
                end
            end
`endif
            EMIT: begin
                // Start is deliberately not looked at here: only Next acts.
                if (Next) begin
                    if (round_q != 4'd0) begin
                        key_d   = inv_step(key_q, round_q);
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Key   = key_q;
    assign Round = round_q;
    assign Valid = (state_q == EMIT);
    assign Ry    = (state_q == IDLE);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed testbench for aes_inv_key_schedule using the FIPS-197 example
// key schedule (cipher key 2b7e1516...4f3c).

module tb_aes_inv_key_schedule;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [127:0] InKey;
    logic         Next;
    logic [127:0] Key;
    logic [3:0]   Round;
    logic         Valid;
    logic         Ry;

    logic [127:0] rk [0:10];
    int n_cmp = 0;
    int n_err = 0;

    aes_inv_key_schedule #(.NR(10)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .InKey (InKey),
        .Next  (Next),
        .Key   (Key),
        .Round (Round),
        .Valid (Valid),
        .Ry    (Ry)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k);
        InKey = k;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic go_idle();
        int guard;
        guard = 0;
        Next = 1'b1;
        while (!Ry && guard < 30) begin
            tick();
            guard++;
        end
        Next = 1'b0;
        n_cmp++;
        if (!Ry) begin
            n_err++;
            $display("FAIL go_idle_timeout: Ry=%0b required 1", Ry);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Start = 1'b0;
        Next = 1'b0;
        InKey = '0;
        tick();
        tick();
        n_cmp++;
        if (Key !== 128'h0 || Round !== 4'd0 || Valid !== 1'b0 || Ry !== 1'b1) begin
            n_err++;
            $display("FAIL reset_values: Key=%h Round=%0d Valid=%b Ry=%b required 0/0/0/1",
                     Key, Round, Valid, Ry);
        end
        Rst = 1'b0;
        tick();
        n_cmp++;
        if (Valid !== 1'b0 || Ry !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: Valid=%b Ry=%b required 0/1", Valid, Ry);
        end
    endtask

`ifndef AES_INV_KEY_DERIVE_EN
    task automatic test_load();
        do_start(rk[10]);
        n_cmp++;
        if (Valid !== 1'b1 || Ry !== 1'b0 || Round !== 4'd10 || Key !== rk[10]) begin
            n_err++;
            $display("FAIL load: Valid=%b Ry=%b Round=%0d Key=%h required 1/0/10/%h",
                     Valid, Ry, Round, Key, rk[10]);
        end
        go_idle();
    endtask

    task automatic test_single_next();
        do_start(rk[10]);
        Next = 1'b1;
        tick();
        Next = 1'b0;
        n_cmp++;
        if (Round !== 4'd9 || Key !== rk[9] || Valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_next: Round=%0d Key=%h Valid=%b required 9/%h/1",
                     Round, Key, Valid, rk[9]);
        end
        tick();
        tick();
        n_cmp++;
        if (Round !== 4'd9 || Key !== rk[9]) begin
            n_err++;
            $display("FAIL hold_stable: Round=%0d Key=%h required 9/%h", Round, Key, rk[9]);
        end
        go_idle();
    endtask

    task automatic test_full_walk();
        do_start(rk[10]);
        Next = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            tick();
            n_cmp++;
            if (Round !== 4'(i) || Key !== rk[i] || Valid !== 1'b1) begin
                n_err++;
                $display("FAIL walk_round_%0d: Round=%0d Key=%h Valid=%b required %0d/%h/1",
                         i, Round, Key, Valid, i, rk[i]);
            end
        end
        tick();
        Next = 1'b0;
        n_cmp++;
        if (Valid !== 1'b0 || Ry !== 1'b1) begin
            n_err++;
            $display("FAIL walk_exit: Valid=%b Ry=%b required 0/1", Valid, Ry);
        end
        // Back-to-back: Start accepted in the first idle cycle.
        do_start(rk[10]);
        n_cmp++;
        if (Valid !== 1'b1 || Round !== 4'd10 || Key !== rk[10]) begin
            n_err++;
            $display("FAIL back_to_back: Valid=%b Round=%0d Key=%h required 1/10/%h",
                     Valid, Round, Key, rk[10]);
        end
        go_idle();
    endtask

    task automatic test_next_ignored_idle();
        Next = 1'b1;
        tick();
        tick();
        Next = 1'b0;
        n_cmp++;
        if (Valid !== 1'b0 || Ry !== 1'b1 || Round !== 4'd0) begin
            n_err++;
            $display("FAIL next_while_invalid: Valid=%b Ry=%b Round=%0d required 0/1/0",
                     Valid, Ry, Round);
        end
    endtask

    task automatic test_start_in_emit();
        do_start(rk[10]);
        Next = 1'b1;
        tick();
        Next = 1'b0;
        do_start({128{1'b1}});
        n_cmp++;
        if (Round !== 4'd9 || Key !== rk[9] || Valid !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_emit: Round=%0d Key=%h Valid=%b required 9/%h/1",
                     Round, Key, Valid, rk[9]);
        end
        Next = 1'b1;
        tick();
        Next = 1'b0;
        n_cmp++;
        if (Round !== 4'd8 || Key !== rk[8]) begin
            n_err++;
            $display("FAIL start_in_emit_after: Round=%0d Key=%h required 8/%h",
                     Round, Key, rk[8]);
        end
        go_idle();
    endtask

    task automatic test_start_next_together();
        do_start(rk[10]);
        InKey = 128'h00112233445566778899aabbccddeeff;
        Start = 1'b1;
        Next = 1'b1;
        tick();
        Start = 1'b0;
        Next = 1'b0;
        n_cmp++;
        if (Round !== 4'd9 || Key !== rk[9] || Valid !== 1'b1) begin
            n_err++;
            $display("FAIL start_next_together: Round=%0d Key=%h Valid=%b required 9/%h/1",
                     Round, Key, Valid, rk[9]);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        do_start(rk[10]);
        Next = 1'b1;
        repeat (5) tick();
        Next = 1'b0;
        n_cmp++;
        if (Round !== 4'd5 || Key !== rk[5]) begin
            n_err++;
            $display("FAIL pre_reset_round5: Round=%0d Key=%h required 5/%h", Round, Key, rk[5]);
        end
        #2;
        Rst = 1'b1;
        #1;
        n_cmp++;
        if (Key !== 128'h0 || Round !== 4'd0 || Valid !== 1'b0 || Ry !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: Key=%h Round=%0d Valid=%b Ry=%b required 0/0/0/1",
                     Key, Round, Valid, Ry);
        end
        tick();
        Rst = 1'b0;
        do_start(rk[10]);
        n_cmp++;
        if (Valid !== 1'b1 || Round !== 4'd10 || Key !== rk[10]) begin
            n_err++;
            $display("FAIL restart_after_reset: Valid=%b Round=%0d Key=%h required 1/10/%h",
                     Valid, Round, Key, rk[10]);
        end
        go_idle();
    endtask
`else
    task automatic test_derive();
        do_start(rk[0]);
        for (int i = 1; i <= 10; i++) begin
            n_cmp++;
            if (Valid !== 1'b0 || Ry !== 1'b0) begin
                n_err++;
                $display("FAIL derive_busy_%0d: Valid=%b Ry=%b required 0/0", i, Valid, Ry);
            end
            tick();
        end
        n_cmp++;
        if (Valid !== 1'b1 || Round !== 4'd10 || Key !== rk[10]) begin
            n_err++;
            $display("FAIL derive_result: Valid=%b Round=%0d Key=%h required 1/10/%h",
                     Valid, Round, Key, rk[10]);
        end
        Next = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            tick();
            n_cmp++;
            if (Round !== 4'(i) || Key !== rk[i]) begin
                n_err++;
                $display("FAIL derive_walk_%0d: Round=%0d Key=%h required %0d/%h",
                         i, Round, Key, i, rk[i]);
            end
        end
        tick();
        Next = 1'b0;
        n_cmp++;
        if (Valid !== 1'b0 || Ry !== 1'b1) begin
            n_err++;
            $display("FAIL derive_exit: Valid=%b Ry=%b required 0/1", Valid, Ry);
        end
    endtask
`endif

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
`ifndef AES_INV_KEY_DERIVE_EN
        test_load();
        test_single_next();
        test_full_walk();
        test_next_ignored_idle();
        test_start_in_emit();
        test_start_next_together();
        test_async_reset();
`else
        test_derive();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
